// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer and the 256x8 instruction memory.
//   ADDR_W_DEF / INSTR_W_DEF : default address / instruction widths
//   fetch_state_e            : sequencer state encoding
package fetch_ctrl_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory + decoder bus of the fetch sequencer.
//   master (fetch_ctrl): drives iAddr, FETCH, instr_out, instr_valid;
//                        receives instr_in, instr_ready, jump_en, jump_addr
//   slave  (memory/decoder side): the mirror image
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) ();

    logic [ADDR_W-1:0]  iAddr;
    logic               FETCH;
    logic [INSTR_W-1:0] instr_in;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               instr_ready;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;

    modport master (
        output iAddr, FETCH, instr_out, instr_valid,
        input  instr_in, instr_ready, jump_en, jump_addr
    );

    modport slave (
        input  iAddr, FETCH, instr_out, instr_valid,
        output instr_in, instr_ready, jump_en, jump_addr
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer. Owns the pc, issues one read per instruction to
// a memory that registers its output one clk after FETCH, and hands each
// instruction to the decoder over valid/ready. One instruction per 3 clks.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, halt           begin/resume fetching (IDLE only); stop (highest priority)
//   pc_load, load_addr    load pc (IDLE only)
//   bus                   fetch_ctrl_if.master: memory and decoder handshake
//   busy, done            state != IDLE; program end reached
//   instr_count           accepted-instruction counter (wraps)
// Build option: FETCH_BOUND_EN -- stop with done=1 after accepting the
// instruction at PROG_END (unless it jumps). Without it pc wraps and done=0.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter int               INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PROG_END = '1,
    parameter int               CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] load_addr,
    fetch_ctrl_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  instr_count
);

    fetch_state_e       state, state_nxt;
    logic [ADDR_W-1:0]  pc, pc_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               capture;
    logic               done_q, done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr_count   <= '0;
            done_q        <= 1'b0;
            bus.instr_out <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_count <= cnt_nxt;
            done_q      <= done_nxt;
            if (capture) bus.instr_out <= bus.instr_in;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = instr_count;
        done_nxt  = done_q;
        capture   = 1'b0;
        if (halt) begin
            // Drops any in-flight instruction; pc still points at it so a
            // later start refetches the same address.
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pc_load) pc_nxt = load_addr;
                    if (start) begin
                        state_nxt = ISSUE;
                        done_nxt  = 1'b0;
                    end
                end
                ISSUE: state_nxt = WAIT;
                WAIT: begin
                    state_nxt = VALID;
                    capture   = 1'b1;
                end
                VALID: begin
                    if (bus.instr_ready) begin
                        pc_nxt    = bus.jump_en ? bus.jump_addr : pc + 1'b1;
                        cnt_nxt   = instr_count + 1'b1;
                        state_nxt = ISSUE;
`ifdef FETCH_BOUND_EN
                        if (pc == PROG_END && !bus.jump_en) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.iAddr       = pc;
    assign bus.FETCH       = (state == ISSUE);
    assign bus.instr_valid = (state == VALID);
    assign busy            = (state != IDLE);
`ifdef FETCH_BOUND_EN
    assign done = done_q;
`else
    assign done = 1'b0;
`endif

endmodule
